// File: rtl/uart_alu_frontend.sv
// uart_alu_frontend: framed, checksummed UART command front-end that launches the ALU and returns status plus result
module uart_alu_frontend #(
  parameter int                 NB_BYTE     = 8,
  parameter int                 NB_DATA     = 16,
  parameter int                 NB_OP       = 6,
  parameter logic [NB_BYTE-1:0] SYNC_BYTE   = 8'hA5,
  parameter int                 ALU_LAT     = 1,
  parameter int                 TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_alu_valid,
  input  logic [NB_DATA-1:0] i_result,
  output logic [2:0]         o_leds
);
  localparam int NBYTES = NB_DATA / NB_BYTE;
  localparam int BW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam int LW = $clog2(ALU_LAT + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [3:0] {HUNT, OP, OPA, OPB, CHK, EXEC, WAIT_RES, TX_SYNC, TX_STAT, TX_RES} state_t;
  state_t state, state_n;
  logic [BW-1:0] bcnt;
  logic [LW-1:0] lcnt;
  logic [TW-1:0] idle;
  logic [NB_BYTE-1:0] op_sh, chk, status;
  logic [NB_DATA-1:0] a_sh, b_sh, res_sh;
  logic sent, err;
  logic rx_phase, tx_phase, last_byte, bad_op, bad_chk, chk_rx, timeout, lat_done, tx_ack;
  assign rx_phase  = state inside {OP, OPA, OPB, CHK};
  assign tx_phase  = state inside {TX_SYNC, TX_STAT, TX_RES};
  assign last_byte = bcnt == BW'(NBYTES - 1);
  assign bad_op    = (op_sh >> NB_OP) != '0;
  assign bad_chk   = i_rx_data != chk;
  assign chk_rx    = state == CHK && i_rx_done;
  assign timeout   = rx_phase && !i_rx_done && idle == TW'(TIMEOUT_CYC);
  assign lat_done  = lcnt == LW'(ALU_LAT - 1);
  assign tx_ack    = tx_phase && sent && i_tx_done;
  // State register; reset aborts any frame or response in flight
  always_ff @(posedge clk)
    state <= !i_rst ? HUNT : state_n;
  // Next-state and output decode; a timeout overrides whatever the receive path was doing
  always_comb begin
    state_n = state;
    if (timeout)
      state_n = TX_SYNC;
    else
      case (state)
        HUNT:     state_n = i_rx_done && i_rx_data == SYNC_BYTE ? OP : HUNT;
        OP:       state_n = i_rx_done ? OPA : OP;
        OPA:      state_n = i_rx_done && last_byte ? OPB : OPA;
        OPB:      state_n = i_rx_done && last_byte ? CHK : OPB;
        CHK:      state_n = !i_rx_done ? CHK : bad_op || bad_chk ? TX_SYNC : EXEC;
        EXEC:     state_n = WAIT_RES;
        WAIT_RES: state_n = lat_done ? TX_SYNC : WAIT_RES;
        TX_SYNC:  state_n = tx_ack ? TX_STAT : TX_SYNC;
        TX_STAT:  state_n = !tx_ack ? TX_STAT : status == '0 ? TX_RES : HUNT;
        TX_RES:   state_n = tx_ack && last_byte ? HUNT : TX_RES;
        default:  state_n = HUNT;
      endcase
    o_tx_start  = tx_phase && !sent;
    o_tx_data   = state == TX_SYNC ? SYNC_BYTE :
                  state == TX_STAT ? status :
                  state == TX_RES  ? res_sh[NB_DATA-1 -: NB_BYTE] : '0;
    o_alu_valid = state == EXEC;
    o_leds      = {err, tx_phase, rx_phase};
  end
  // Datapath: shadow capture, checksum, counters, operand/result registers and sticky error
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      bcnt     <= '0;
      lcnt     <= '0;
      idle     <= '0;
      op_sh    <= '0;
      chk      <= '0;
      status   <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      sent     <= 1'b0;
      err      <= 1'b0;
      o_op     <= '0;
      o_data_a <= '0;
      o_data_b <= '0;
    end else begin
      bcnt <= state_n != state ? '0 :
              (i_rx_done && state inside {OPA, OPB}) || (tx_ack && state == TX_RES) ? bcnt + BW'(1) : bcnt;
      lcnt <= state == WAIT_RES ? lcnt + LW'(1) : '0;
      idle <= i_rx_done || !rx_phase ? '0 : idle + TW'(1);
      sent <= tx_phase && (sent ? !i_tx_done : 1'b1);
      if (state == HUNT)
        chk <= '0;
      else if (i_rx_done && state inside {OP, OPA, OPB})
        chk <= chk ^ i_rx_data;
      if (i_rx_done && state == OP)
        op_sh <= i_rx_data;
      if (i_rx_done && state == OPA)
        a_sh <= (a_sh << NB_BYTE) | NB_DATA'(i_rx_data);
      if (i_rx_done && state == OPB)
        b_sh <= (b_sh << NB_BYTE) | NB_DATA'(i_rx_data);
      if (timeout)
        status <= NB_BYTE'(3);
      else if (chk_rx)
        status <= bad_op ? NB_BYTE'(2) : bad_chk ? NB_BYTE'(1) : '0;
      if (chk_rx && !bad_op && !bad_chk) begin
        o_op     <= op_sh[NB_OP-1:0];
        o_data_a <= a_sh;
        o_data_b <= b_sh;
      end
      if (state == WAIT_RES && lat_done)
        res_sh <= i_result;
      else if (tx_ack && state == TX_RES)
        res_sh <= res_sh << NB_BYTE;
      if (timeout || (chk_rx && (bad_op || bad_chk)))
        err <= 1'b1;
      else if (tx_ack && state == TX_RES && last_byte)
        err <= 1'b0;
    end
  end
endmodule

// File: doc/uart_alu_frontend.md
# uart_alu_frontend

Framed command front-end between `uart_rx`/`uart_tx` and the ALU, replacing the single-byte `interface` block.
- Receives a sync-delimited, checksummed frame carrying opcode and two multi-byte operands of parametrised width.
- Launches the ALU with a one-cycle valid, captures the result after a fixed latency and returns status plus result bytes over TX.
- Adds inter-byte timeout, error reporting and resynchronisation, none of which the single-byte interface has.

## Interface
- `NB_BYTE`, 8, UART character width.
- `NB_DATA`, 16, operand/result width; must be a multiple of `NB_BYTE`; `NBYTES = NB_DATA/NB_BYTE`.
- `NB_OP`, 6, opcode width; must be ≤ `NB_BYTE`.
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `ALU_LAT`, 1, cycles from `o_alu_valid` to `i_result` valid; must be ≥ 1.
- `TIMEOUT_CYC`, 1000000, inter-byte timeout in clocks; must be ≥ 1.

Ports:
- `clk` in 1: single system clock.
- `i_rst` in 1: reset, synchronous, active-low.
- `i_rx_data` in NB_BYTE: received byte; valid when `i_rx_done`=1.
- `i_rx_done` in 1: one-cycle pulse per received byte.
- `o_tx_data` out NB_BYTE: byte to transmit.
- `o_tx_start` out 1: one-cycle request to transmit `o_tx_data`.
- `i_tx_done` in 1: one-cycle pulse when the TX byte has completed.
- `o_data_a`, `o_data_b` out NB_DATA: ALU operands.
- `o_op` out NB_OP: ALU opcode.
- `o_alu_valid` out 1: one-cycle ALU launch pulse.
- `i_result` in NB_DATA: ALU result.
- `o_leds` out 3:
  - [0] frame reception in progress.
  - [1] response transmitting.
  - [2] sticky error.

## Operation
- **Request frame:** SYNC, OP, A[MSB byte first], B[MSB byte first], CHK.
  - CHK = XOR of every byte after SYNC, excluding CHK.
  - OP bits above `NB_OP` must be zero.
- **Response frame:** SYNC, STATUS, then result bytes (MSB first) only when STATUS=8'h00.
- **STATUS codes:**
  - 8'h00: ok.
  - 8'h01: checksum error.
  - 8'h02: illegal opcode bits. Takes precedence when the checksum also fails.
  - 8'h03: timeout.
- **FSM states:** HUNT, OP, OPA, OPB, CHK, EXEC, WAIT_RES, TX_SYNC, TX_STAT, TX_RES.
- **Receive path:**
  - HUNT: non-SYNC bytes are discarded; SYNC moves to OP.
  - OP, OPA and OPB accumulate bytes into shadow registers. A byte counter runs 0..NBYTES-1, clears on each field change and never wraps past NBYTES-1.
  - CHK, on the check byte:
    - If good: copy shadow registers to `o_op`/`o_data_a`/`o_data_b`, pulse `o_alu_valid`, go to EXEC.
    - If bad: load the status code and go to TX_SYNC. Outputs and ALU are untouched.
  - EXEC/WAIT_RES: count `ALU_LAT` cycles, capture `i_result` into the TX shift register, go to TX_SYNC.
- **Transmit path:**
  - Each byte is sent as an `o_tx_start` pulse, then the FSM holds `o_tx_data` stable until `i_tx_done`.
  - TX_RES sends NBYTES bytes, then returns to HUNT.
- **Timeout:** a counter clears on every `i_rx_done`. In OP..CHK, reaching `TIMEOUT_CYC` idle cycles aborts with status 03.
- **Ignored inputs:**
  - `i_rx_done` in EXEC..TX_RES is ignored: the byte is dropped and no queueing occurs.
  - `i_tx_done` outside the TX wait is ignored.
- **LEDs:** `o_leds[2]` sets on any non-zero status and clears when an ok response completes.

## Timing
- **Reset values** (when `i_rst`=0 at a rising edge):
  - State HUNT; all counters 0.
  - All outputs 0, including `o_data_a`, `o_data_b`, `o_op`, `o_leds`.
- Reset mid-frame or mid-response aborts immediately. No partial response continues after release.
- `o_alu_valid` is high the cycle after the cycle in which CHK's `i_rx_done` is sampled. Operands are stable from that cycle until the next good frame.
- `i_result` is sampled exactly `ALU_LAT` cycles after the `o_alu_valid` cycle.
- First `o_tx_start` occurs the cycle after result capture (ok path) or the cycle after CHK/timeout detection (error path).
- The next `o_tx_start` occurs the cycle after each `i_tx_done`. `o_tx_start` is never asserted twice without an intervening `i_tx_done`.
- Timeout fires when the idle count equals `TIMEOUT_CYC`. Simultaneous `i_rx_done` wins: the byte is accepted and the counter clears.
- After the final `i_tx_done`, the FSM is in HUNT on the next cycle and accepts a SYNC arriving that same cycle.

## Test plan
All scenarios use NB_DATA=16; the bench ALU model returns 16'h1335, and the bench TX model pulses `i_tx_done` 10 cycles after each start.
- **Good frame:** RX A5 20 12 34 01 01 06 -> one `o_alu_valid` with op=6'h20, A=16'h1234, B=16'h0101; TX A5 00 13 35; `o_leds[2]`=0.
- **Bad checksum:** RX A5 20 12 34 01 01 07 -> no `o_alu_valid`; operands unchanged; TX A5 01; `o_leds[2]`=1.
- **Illegal opcode:** RX A5 C0 12 34 01 01 E6 -> TX A5 02; no `o_alu_valid`.
- **Timeout:** RX A5 20 12 then silence `TIMEOUT_CYC` cycles -> TX A5 03.
- **Recovery:** a subsequent good frame gives TX A5 00 13 35 and clears `o_leds[2]`.
- **Resync:** RX 00 FF 5A then the good frame -> identical response to the good-frame case. Bytes arriving during TX are dropped and generate no second response.
- **Reset mid-response:** assert `i_rst`=0 for 1 cycle after TX of A5 -> all outputs 0 next cycle; no further `o_tx_start`; a fresh good frame then completes normally.
